recip_lut_div: RTL



---
 rtl/recip_pkg.sv | 23 ++
 rtl/recip_lut_div_if.sv | 25 ++
 rtl/recip_div_core.sv | 68 ++++++
 rtl/recip_lut_div.sv | 95 +++++++++
 4 files changed

// File: rtl/recip_pkg.sv
// Shared types, default constants and range helper for the reciprocal divider.
package recip_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_IN_W      = 11;
  localparam int unsigned DEF_OUT_W     = 8;
  localparam int unsigned DEF_TAG_W     = 8;
  localparam int unsigned DEF_NUMERATOR = 38400;
  localparam int unsigned DEF_SAT_BELOW = 193;
  localparam int unsigned DEF_MAX_IN    = 1250;
  localparam int unsigned DEF_SAT_VAL   = 255;

  function automatic logic in_range(input int unsigned x, input int unsigned lo,
                                    input int unsigned hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/recip_lut_div_if.sv
// Valid/ready request and response streams of the reciprocal divider.
interface recip_lut_div_if #(
  parameter int unsigned IN_W  = 11,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/recip_div_core.sv
// Restoring divider: one quotient bit per cycle, MSB first, N_W steps after start_i.
module recip_div_core
  import recip_pkg::*;
#(
  parameter int unsigned IN_W = DEF_IN_W,
  parameter int unsigned N_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [N_W-1:0]  dividend_i,
  input  logic [IN_W-1:0] divisor_i,
  output logic            last_o,
  output logic [N_W-1:0]  quot_next_o
);
  localparam int unsigned CNT_W = $clog2(N_W + 1);

  logic [IN_W:0]      rem_q, rem_d;
  logic [N_W-1:0]     acc_q, acc_d;
  logic [IN_W-1:0]    dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IN_W+1:0]    rem_sh;
  logic               ge;
  logic [IN_W:0]      rem_step;
  logic [N_W-1:0]     acc_step;

  // acc_q shifts dividend bits out at the top and quotient bits in at the bottom
  always_comb begin
    rem_sh   = {rem_q, acc_q[N_W-1]};
    ge       = rem_sh >= {2'b00, dvs_q};
    rem_step = ge ? (IN_W+1)'(rem_sh - {2'b00, dvs_q}) : (IN_W+1)'(rem_sh);
    acc_step = {acc_q[N_W-2:0], ge};
  end

  always_comb begin
    rem_d = rem_q;
    acc_d = acc_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (start_i) begin
      rem_d = '0;
      acc_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = CNT_W'(N_W);
    end else if (cnt_q != '0) begin
      rem_d = rem_step;
      acc_d = acc_step;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      acc_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      acc_q <= acc_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o      = (cnt_q == CNT_W'(1));
  assign quot_next_o = acc_step;
endmodule

// File: rtl/recip_lut_div.sv
// Saturating floor(NUMERATOR / x) with tag passthrough and out-of-range bypass.
// Optional RECIP_ROUND_NEAREST_EN: divide (NUMERATOR + x/2) for round-to-nearest.
module recip_lut_div
  import recip_pkg::*;
#(
  parameter int unsigned IN_W      = DEF_IN_W,
  parameter int unsigned OUT_W     = DEF_OUT_W,
  parameter int unsigned TAG_W     = DEF_TAG_W,
  parameter int unsigned NUMERATOR = DEF_NUMERATOR,
  parameter int unsigned SAT_BELOW = DEF_SAT_BELOW,
  parameter int unsigned MAX_IN    = DEF_MAX_IN,
  parameter int unsigned SAT_VAL   = DEF_SAT_VAL
) (
  input  logic clk,
  input  logic rst,
  recip_lut_div_if.slave bus,
  output logic busy
);
`ifdef RECIP_ROUND_NEAREST_EN
  localparam int unsigned N_W = $clog2(NUMERATOR + (1 << (IN_W - 1)) + 1);
`else
  localparam int unsigned N_W = $clog2(NUMERATOR + 1);
`endif
  localparam logic [N_W:0] OUT_MAX = (N_W+1)'((1 << OUT_W) - 1);

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               start;
  logic [N_W-1:0]     dividend;
  logic               last;
  logic [N_W-1:0]     quot_next;

`ifdef RECIP_ROUND_NEAREST_EN
  assign dividend = N_W'(NUMERATOR) + N_W'(bus.in_data >> 1);
`else
  assign dividend = N_W'(NUMERATOR);
`endif

  recip_div_core #(
    .IN_W (IN_W),
    .N_W  (N_W)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .dividend_i  (dividend),
    .divisor_i   (bus.in_data),
    .last_o      (last),
    .quot_next_o (quot_next)
  );

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    start      = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        out_tag_d = bus.in_tag;
        if (in_range(32'(bus.in_data), SAT_BELOW, MAX_IN)) begin
          start   = 1'b1;
          state_d = DIV;
        end else begin
          out_data_d = OUT_W'(SAT_VAL);
          state_d    = DONE;
        end
      end
      DIV: if (last) begin
        out_data_d = ({1'b0, quot_next} > OUT_MAX) ? OUT_W'(SAT_VAL) : quot_next[OUT_W-1:0];
        state_d    = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign busy          = (state_q != IDLE);
endmodule
